// File: rtl/handshake_master.sv
// FIFO-buffered valid/ready source: words from a local producer are queued and
// presented one at a time, held stable until accepted. Optional build macro:
// HS_MASTER_PATTERN_GEN_EN replaces in_data with an internal incrementing pattern.
module handshake_master #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              M_valid,
   output logic [DATA_W-1:0] M_data,
   input  logic              M_ready,
   output logic [ADDR_W:0]   fifo_count,
   output logic [15:0]       tx_count
);

   // state  | meaning
   // S_IDLE | output register empty, M_valid low
   // S_SEND | output register holds a word, M_valid high until accepted
   typedef enum logic {S_IDLE, S_SEND} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t             state, state_next;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
   logic [DATA_W-1:0]  wr_data;
   logic               push, pop, xfer;

   assign in_ready = (fifo_count != FULL_CNT);
   assign push     = in_valid && in_ready;
   assign xfer     = M_valid && M_ready;

`ifdef HS_MASTER_PATTERN_GEN_EN
   logic [DATA_W-1:0] pat_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         pat_cnt <= '0;
      else if (push)
         pat_cnt <= pat_cnt + 1'b1;
   end

   assign wr_data = pat_cnt;
`else
   assign wr_data = in_data;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // The pop decision sees only the registered count, so a same-cycle write never bypasses.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_count != '0) begin
               pop        = 1'b1;
               state_next = S_SEND;
            end
         end
         S_SEND: begin
            if (M_ready) begin
               if (fifo_count != '0)
                  pop = 1'b1;
               else
                  state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      M_valid = (state == S_SEND);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         M_data     <= '0;
         tx_count   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            M_data <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (xfer)
            tx_count <= tx_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_handshake_master.sv
// Directed self-checking bench for handshake_master: a vector table for reset,
// single-word and full-boundary behaviour, plus sequences for stalls, wrap and reset.
module tb_handshake_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       M_valid;
   logic [7:0] M_data;
   logic       M_ready = 1'b0;
   logic [3:0] fifo_count;
   logic [15:0] tx_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   handshake_master #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .M_valid    (M_valid),
      .M_data     (M_data),
      .M_ready    (M_ready),
      .fifo_count (fifo_count),
      .tx_count   (tx_count)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [7:0]  d;
      logic        mr;
      logic        ev;
      logic [7:0]  ed;
      logic        cd;
      logic [3:0]  efc;
      logic        eir;
      logic [15:0] etx;
   } vec_t;

   vec_t vt[26];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setv(input int i, input logic r, input logic iv, input logic [7:0] d,
                       input logic mr, input logic ev, input logic [7:0] ed, input logic cd,
                       input logic [3:0] efc, input logic eir, input logic [15:0] etx);
      vt[i].rst = r;  vt[i].iv = iv;  vt[i].d = d;   vt[i].mr = mr;
      vt[i].ev = ev;  vt[i].ed = ed;  vt[i].cd = cd; vt[i].efc = efc;
      vt[i].eir = eir; vt[i].etx = etx;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; in_valid = 1'b0; M_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] q[$];
      logic       held;
      logic [7:0] hd;
      int         seen, bad, wr_idx, gaps;
      logic       push_now;

`ifndef HS_MASTER_PATTERN_GEN_EN
      //        i   rst iv d      mr ev ed     cd efc eir etx
      setv( 0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0);
      setv( 1, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0);
      setv( 2, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0);
      setv( 3, 0, 1, 8'hA5, 1, 0, 8'h00, 1, 1, 1, 0);
      setv( 4, 0, 0, 8'h00, 1, 1, 8'hA5, 1, 0, 1, 0);
      setv( 5, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1);
      setv( 6, 0, 1, 8'h10, 0, 0, 8'h00, 0, 1, 1, 1);
      setv( 7, 0, 1, 8'h11, 0, 1, 8'h10, 1, 1, 1, 1);
      for (int k = 0; k < 7; k++)
         setv(8 + k, 0, 1, 8'(8'h12 + k), 0, 1, 8'h10, 1, 4'(2 + k), (k != 6), 1);
      setv(15, 0, 1, 8'h19, 0, 1, 8'h10, 1, 8, 0, 1);
      setv(16, 0, 0, 8'h00, 1, 1, 8'h11, 1, 7, 1, 2);
      for (int k = 0; k < 7; k++)
         setv(17 + k, 0, 0, 8'h00, 1, 1, 8'(8'h12 + k), 1, 4'(6 - k), 1, 16'(3 + k));
      setv(24, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 10);
      setv(25, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 10);

      #1;
      for (int i = 0; i < 26; i++) begin
         rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].d; M_ready = vt[i].mr;
         tick();
         chk($sformatf("vec%0d_M_valid", i), 32'(M_valid), 32'(vt[i].ev));
         if (vt[i].cd)
            chk($sformatf("vec%0d_M_data", i), 32'(M_data), 32'(vt[i].ed));
         chk($sformatf("vec%0d_fifo_count", i), 32'(fifo_count), 32'(vt[i].efc));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].eir));
         chk($sformatf("vec%0d_tx_count", i), 32'(tx_count), 32'(vt[i].etx));
      end

      // Burst of 8 against a 1,1,1,0 ready pattern.
      pulse_reset();
      held = 1'b0; hd = 8'h00;
      for (int c = 0; c < 40; c++) begin
         in_valid = (c < 8);
         in_data  = 8'(c + 1);
         M_ready  = (c % 4) != 3;
         if (c < 8 && !in_ready) chk("burst_in_ready", 32'(in_ready), 32'd1);
         if (M_valid && M_ready) q.push_back(M_data);
         held = M_valid && !M_ready;
         hd   = M_data;
         tick();
         if (held) begin
            chk("stall_hold_data", 32'(M_data), 32'(hd));
            chk("stall_hold_valid", 32'(M_valid), 32'd1);
         end
      end
      chk("burst_len", 32'(q.size()), 32'd8);
      for (int i = 0; i < q.size() && i < 8; i++)
         chk($sformatf("burst_word%0d", i), 32'(q[i]), 32'(i + 1));
      chk("burst_tx_count", 32'(tx_count), 32'd8);
      chk("burst_fifo_count", 32'(fifo_count), 32'd0);

      // Force 65536 transfers and check the counter wraps.
      pulse_reset();
      seen = 0; bad = 0; wr_idx = 0;
      M_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
      for (int c = 0; c < 70000 && seen < 65536; c++) begin
         push_now = in_ready;
         if (M_valid) begin
            if (M_data !== 8'(seen)) bad++;
            seen++;
         end
         tick();
         if (push_now) wr_idx++;
         in_data = 8'(wr_idx);
      end
      M_ready = 1'b0; in_valid = 1'b0;
      chk("wrap_transfers_seen", 32'(seen), 32'd65536);
      chk("wrap_order_errors", 32'(bad), 32'd0);
      chk("wrap_tx_count", 32'(tx_count), 32'd0);

      M_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("drain_M_valid", 32'(M_valid), 32'd0);
      chk("drain_fifo_count", 32'(fifo_count), 32'd0);
      M_ready = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_data = 8'(8'hC0 + c);
         tick();
      end
      in_valid = 1'b0;
      chk("prerst_M_valid", 32'(M_valid), 32'd1);
      chk("prerst_fifo_count", 32'(fifo_count), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_M_valid", 32'(M_valid), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_M_data", 32'(M_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      M_ready = 1'b1;
      gaps = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (M_valid !== 1'b0) gaps++;
      end
      chk("postrst_no_output", 32'(gaps), 32'd0);
      chk("postrst_tx_count", 32'(tx_count), 32'd0);
`else
      #1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("pg_reset_M_valid", 32'(M_valid), 32'd0);
      chk("pg_reset_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 8'h5A; M_ready = 1'b1;
      gaps = 0; bad = 0;
      for (int c = 0; c < 300; c++) begin
         if (M_valid) q.push_back(M_data);
         else if (q.size() > 0) gaps++;
         in_data = 8'(c * 7);
         tick();
      end
      chk("pg_min_words", 32'(q.size() >= 290), 32'd1);
      for (int i = 0; i < q.size(); i++)
         if (q[i] !== 8'(i)) bad++;
      chk("pg_sequence_errors", 32'(bad), 32'd0);
      chk("pg_gaps", 32'(gaps), 32'd0);
      chk("pg_tx_count", 32'(tx_count), 32'(q.size()));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/handshake_master.md
Name: handshake_master

Overview:
- Upstream stage that feeds the team's 8-bit valid/ready slave receiver.
- Accepts words from a local producer into a small FIFO and presents them one at a time on a valid/ready output port.
- Holds every presented word stable until the downstream ready accepts it, so the receiver's 3-on/1-off ready pattern never drops or duplicates data.
- Keeps an occupancy count and a transfer counter for debug.

Parameters:
DATA_W, 8, data word width
DEPTH, 8, FIFO depth in words; must be a power of two, at least 2
ADDR_W, 3, FIFO pointer width; equals log2(DEPTH)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_W  producer word
in_ready  output  1  FIFO can accept a word; equals not-full
M_valid  output  1  M_data holds a valid word
M_data  output  DATA_W  word presented downstream; connects to slave S_data
M_ready  input  1  downstream accepts; connects from slave S_ready
fifo_count  output  ADDR_W+1  words in FIFO, range 0..DEPTH; excludes the output register
tx_count  output  16  completed output transfers; wraps modulo 2^16

Behaviour:
- Reset: synchronous. On a clk edge with rst=1:
  - M_valid=0, M_data=0, fifo_count=0, tx_count=0, FIFO pointers=0, state=IDLE.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-burst discards FIFO contents and the word held in the output register. No transfer completes on the reset edge.
- Input write: on an edge where in_valid && in_ready, in_data is written at wr_ptr. wr_ptr wraps DEPTH-1 to 0.
- in_ready is derived only from the registered fifo_count (in_ready = fifo_count != DEPTH). A pop in the same cycle does not admit a write into a full FIFO.
- Output transfer: completes on an edge where M_valid && M_ready.
  - When it completes, tx_count increments; 0xFFFF wraps to 0x0000.
- Output stability:
  - While M_valid=1 and M_ready=0, M_data and M_valid hold their values.
  - M_valid never drops without a completed transfer, except on reset.
- State machine (output register):
  - IDLE: M_valid=0.
    - If fifo_count>0: pop the FIFO head into M_data, set M_valid=1, go to SEND.
    - Otherwise stay in IDLE.
  - SEND: M_valid=1.
    - On a completed transfer with fifo_count>0: pop the next word into M_data and stay in SEND. Back-to-back transfers run at 1 word/cycle.
    - On a completed transfer with fifo_count=0: M_valid=0, go to IDLE.
    - With no transfer: hold.
- Latency: a word written at edge N into an empty FIFO with the output idle appears with M_valid=1 after edge N+1.
  - The FIFO does not bypass; the write is not visible to the pop decision in the same cycle.
- Simultaneous push and pop: fifo_count stays unchanged. Pointers advance independently.
- Capacity: DEPTH words in the FIFO plus 1 in the output register. With M_ready held at 0, DEPTH+1 words are accepted before in_ready falls.
- Ordering: strict FIFO order; no reordering or duplication.

Optional Feature:
- Macro: HS_MASTER_PATTERN_GEN_EN.
- When defined:
  - in_data is ignored.
  - An internal DATA_W-bit pattern counter, reset to 0, supplies the write data.
  - A write occurs on every edge where in_valid=1 and the FIFO is not full; the counter then increments, wrapping to 0.
  - in_ready behaves as normal.
- When not defined: no pattern counter exists and FIFO data comes from in_data.
- The port list is identical in both builds.

Test Plan:
1. Reset then idle, rst held 2 cycles → M_valid=0, M_data=0x00, fifo_count=0, tx_count=0, in_ready=1.
2. Single word: write 0xA5 at edge N with M_ready=1 → M_valid=1 and M_data=0xA5 after N+1; transfer at N+2; M_valid=0 after N+2; tx_count=1.
3. Burst against stalling ready:
   - Stimulus: write 0x01..0x08 on consecutive cycles; M_ready repeats the pattern 1,1,1,0.
   - Required: output sequence is exactly 0x01..0x08; M_data is unchanged across every M_ready=0 cycle; tx_count=8; final fifo_count=0.
4. Full boundary:
   - Stimulus: M_ready=0; present 10 words.
   - Required: 9 are accepted (M_data=first word, fifo_count=8); in_ready=0 while the 10th is presented, and it is not written.
   - Then raise M_ready for 1 cycle: fifo_count=7 and in_ready=1 on the next cycle.
5. Wrap and reset:
   - Stimulus: force 65536 transfers.
   - Required: tx_count wraps to 0x0000.
   - Then assert rst with 3 words buffered and M_valid=1: next cycle M_valid=0, fifo_count=0, and no further output words.
6. With HS_MASTER_PATTERN_GEN_EN defined: in_valid=1 and M_ready=1 for 300 cycles → output sequence is 0x00,0x01,...,0xFF,0x00,... with no gaps after the first word.
